// File: rtl/joy_serializer_pkg.sv
// Shared constants, slot-to-bit map and state encoding for the joystick serializer.
package joy_pkg;

  localparam int JOY_FRAME_SLOTS = 25;
  localparam int JOY_BITS        = 12;
  localparam int JOY_LAST_SLOT   = JOY_FRAME_SLOTS - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } joy_state_e;

  // Each entry indexes the captured word {joy_b, joy_a}; slot 0 is the fixed 1 and its entry is unused.
  localparam logic [4:0] JOY_SLOT_MAP [JOY_FRAME_SLOTS] = '{
    5'd0,
    5'd8,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd0,
    5'd20, 5'd18, 5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12,
    5'd22, 5'd23, 5'd21, 5'd19,
    5'd10, 5'd11, 5'd9,  5'd7
  };

endpackage

// File: rtl/joy_serializer_if.sv
// Pin-level bundle between a joystick port master and the serializer.
interface joy_serializer_if;
  import joy_pkg::*;

  logic                joy_clk;
  logic                joy_load;
  logic                joy_data;
  logic                frame_done;
  logic [JOY_BITS-1:0] joy_a;
  logic [JOY_BITS-1:0] joy_b;

  modport master (
    output joy_clk, joy_load, joy_a, joy_b,
    input  joy_data, frame_done
  );

  modport slave (
    input  joy_clk, joy_load, joy_a, joy_b,
    output joy_data, frame_done
  );

endinterface

// File: rtl/joy_serializer_sync2.sv
// Two-flop synchronizer with a selectable reset value.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic pclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge pclk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joy_serializer.sv
// Serializes two 12-button player inputs onto a master-clocked load/shift joystick port.
//
// state | meaning
// IDLE  | no frame in progress (reset or watchdog), joy_data held at 1
// SHIFT | presenting slots 0..24; slot 24 stays on the pin until the next shift edge
// HOLD  | frame finished, joy_data held at 1 until the next load
module joy_serializer
  import joy_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic                joy_clk,
  input  logic                joy_load,
  output logic                joy_data,
  input  logic [JOY_BITS-1:0] joy_a,
  input  logic [JOY_BITS-1:0] joy_b,
  output logic                frame_done
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic                  sclk_s;
  logic                  sclk_d;
  logic                  sload_s;
  logic                  sclk_rise;
  joy_state_e            state;
  logic [4:0]            slot;
  logic [4:0]            slot_next;
  logic [2*JOY_BITS-1:0] frame;
  logic                  next_bit;
  logic [WD_W-1:0]       wdog;

  sync2 #(.RESET_VAL(1'b0)) u_sync_clk (
    .pclk  (pclk),
    .reset (reset),
    .d     (joy_clk),
    .q     (sclk_s)
  );

  sync2 #(.RESET_VAL(1'b1)) u_sync_load (
    .pclk  (pclk),
    .reset (reset),
    .d     (joy_load),
    .q     (sload_s)
  );

  assign sclk_rise = sclk_s & ~sclk_d;
  assign slot_next = (slot == 5'(JOY_LAST_SLOT)) ? slot : slot + 5'd1;
  assign next_bit  = frame[JOY_SLOT_MAP[slot_next]];

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= IDLE;
      slot       <= 5'd0;
      frame      <= '1;
      joy_data   <= 1'b1;
      frame_done <= 1'b0;
      wdog       <= '0;
      sclk_d     <= 1'b0;
    end else begin
      sclk_d     <= sclk_s;
      frame_done <= 1'b0;
      if (sclk_rise) begin
        wdog <= '0;
        if (!sload_s) begin
          frame    <= {joy_b, joy_a};
          slot     <= 5'd0;
          state    <= SHIFT;
          joy_data <= 1'b1;
        end else begin
          case (state)
            SHIFT: begin
              if (slot != 5'(JOY_LAST_SLOT)) begin
                slot       <= slot_next;
                joy_data   <= next_bit;
                frame_done <= (slot_next == 5'(JOY_LAST_SLOT));
              end else begin
                state    <= HOLD;
                joy_data <= 1'b1;
              end
            end
            default: joy_data <= 1'b1;
          endcase
        end
      end else if (wdog == WD_W'(TIMEOUT)) begin
        // Master went quiet: drop any partial frame so the pin idles high.
        state    <= IDLE;
        joy_data <= 1'b1;
      end else begin
        wdog <= wdog + WD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_joy_serializer.sv
// Randomized self-checking bench: load/shift frames against a slot-list model, plus watchdog and reset cases.
module tb_joy_serializer;
  import joy_pkg::*;

  logic pclk  = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   fd1 = 0;
  int   fd2 = 0;

  joy_serializer_if j1 ();
  joy_serializer_if j2 ();

  always #5 pclk = ~pclk;

  joy_serializer u_dut (
    .pclk       (pclk),
    .reset      (reset),
    .joy_clk    (j1.joy_clk),
    .joy_load   (j1.joy_load),
    .joy_data   (j1.joy_data),
    .joy_a      (j1.joy_a),
    .joy_b      (j1.joy_b),
    .frame_done (j1.frame_done)
  );

  joy_serializer #(.TIMEOUT(16)) u_dut_wd (
    .pclk       (pclk),
    .reset      (reset),
    .joy_clk    (j2.joy_clk),
    .joy_load   (j2.joy_load),
    .joy_data   (j2.joy_data),
    .joy_a      (j2.joy_a),
    .joy_b      (j2.joy_b),
    .frame_done (j2.frame_done)
  );

  always @(negedge pclk) begin
    if (j1.frame_done === 1'b1) fd1++;
    if (j2.frame_done === 1'b1) fd2++;
  end

  // Expected pin value for each slot 0..24, built from the button lists.
  function automatic logic [24:0] model_frame(input logic [11:0] a, input logic [11:0] b);
    int          body [8];
    int          tail [4];
    logic [24:0] f;
    body = '{8, 6, 5, 4, 3, 2, 1, 0};
    tail = '{10, 11, 9, 7};
    f[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = a[body[i]];
      f[9 + i] = b[body[i]];
    end
    for (int i = 0; i < 4; i++) begin
      f[17 + i] = b[tail[i]];
      f[21 + i] = a[tail[i]];
    end
    return f;
  endfunction

  // One 32-pclk joy_clk period on j1; samples joy_data 2 and 3 pclk edges after the pin rise.
  task automatic rise1(input logic ld, output logic early, output logic late, output logic fd);
    @(negedge pclk);
    j1.joy_load = ld;
    repeat (15) @(negedge pclk);
    j1.joy_clk = 1'b1;
    repeat (2) @(posedge pclk);
    #1 early = j1.joy_data;
    @(posedge pclk);
    #1 late = j1.joy_data;
    fd = j1.frame_done;
    repeat (14) @(negedge pclk);
    j1.joy_clk = 1'b0;
  endtask

  // One 8-pclk joy_clk period on j2 (4 high, 4 low).
  task automatic rise2(input logic ld, output logic late);
    @(negedge pclk);
    j2.joy_load = ld;
    repeat (3) @(negedge pclk);
    j2.joy_clk = 1'b1;
    repeat (3) @(posedge pclk);
    #1 late = j2.joy_data;
    repeat (2) @(negedge pclk);
    j2.joy_clk = 1'b0;
  endtask

  task automatic play_frame(input logic [11:0] a_after, input logic [11:0] b_after,
                            output logic [24:0] early, output logic [24:0] late,
                            output logic [24:0] done);
    logic e, l, d;
    rise1(1'b0, e, l, d);
    early[0] = e; late[0] = l; done[0] = d;
    j1.joy_a = a_after;
    j1.joy_b = b_after;
    for (int s = 1; s < 25; s++) begin
      rise1(1'b1, e, l, d);
      early[s] = e; late[s] = l; done[s] = d;
    end
  endtask

  task automatic test_reset();
    logic e, l, d;
    reset = 1'b1;
    repeat (3) @(posedge pclk);
    #1 reset = 1'b0;
    @(negedge pclk);
    checks++;
    if (j1.joy_data !== 1'b1) begin errors++; $display("FAIL reset_data got=%b want=1", j1.joy_data); end
    checks++;
    if (j1.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", j1.frame_done); end
    checks++;
    if (j2.joy_data !== 1'b1) begin errors++; $display("FAIL reset_data_wd got=%b want=1", j2.joy_data); end
    rise1(1'b1, e, l, d);
    checks++;
    if (l !== 1'b1) begin errors++; $display("FAIL idle_edge_data got=%b want=1", l); end
    checks++;
    if (fd1 !== 0) begin errors++; $display("FAIL idle_edge_done count=%0d want=0", fd1); end
  endtask

  task automatic test_full_frame();
    logic [24:0] want, early, late, done;
    logic        e, l, d;
    int          fd0;
    j1.joy_a = 12'hFFE;
    j1.joy_b = 12'hEFF;
    want = model_frame(12'hFFE, 12'hEFF);
    fd0 = fd1;
    play_frame(12'hFFE, 12'hEFF, early, late, done);
    for (int s = 0; s < 25; s++) begin
      checks++;
      if (late[s] !== want[s]) begin errors++; $display("FAIL full_slot%0d got=%b want=%b", s, late[s], want[s]); end
      checks++;
      if (done[s] !== (s == 24)) begin errors++; $display("FAIL full_done_slot%0d got=%b want=%b", s, done[s], s == 24); end
      if (s > 0 && want[s] !== want[s-1]) begin
        checks++;
        if (early[s] !== want[s-1]) begin errors++; $display("FAIL full_latency_slot%0d got=%b want=%b", s, early[s], want[s-1]); end
      end
    end
    checks++;
    if (fd1 - fd0 !== 1) begin errors++; $display("FAIL full_done_count got=%0d want=1", fd1 - fd0); end
    for (int k = 0; k < 2; k++) begin
      rise1(1'b1, e, l, d);
      checks++;
      if (l !== 1'b1) begin errors++; $display("FAIL hold_edge%0d got=%b want=1", k, l); end
    end
    checks++;
    if (fd1 - fd0 !== 1) begin errors++; $display("FAIL hold_done_count got=%0d want=1", fd1 - fd0); end
  endtask

  task automatic test_midframe_change();
    logic [24:0] want, early, late, done;
    logic [11:0] a, b, b2;
    a  = 12'($urandom);
    b  = 12'($urandom);
    b2 = 12'($urandom);
    j1.joy_a = a;
    j1.joy_b = b;
    want = model_frame(a, b);
    play_frame(12'h000, b2, early, late, done);
    for (int s = 0; s < 25; s++) begin
      checks++;
      if (late[s] !== want[s]) begin errors++; $display("FAIL midchg_slot%0d got=%b want=%b", s, late[s], want[s]); end
    end
    want = model_frame(12'h000, b2);
    play_frame(12'h000, b2, early, late, done);
    for (int s = 0; s < 25; s++) begin
      checks++;
      if (late[s] !== want[s]) begin errors++; $display("FAIL nextload_slot%0d got=%b want=%b", s, late[s], want[s]); end
    end
  endtask

  task automatic test_random_frames();
    logic [24:0] want, early, late, done;
    logic [11:0] a, b;
    int          fd0;
    for (int n = 0; n < 3; n++) begin
      a = 12'($urandom);
      b = 12'($urandom);
      j1.joy_a = a;
      j1.joy_b = b;
      want = model_frame(a, b);
      fd0 = fd1;
      play_frame(12'($urandom), 12'($urandom), early, late, done);
      for (int s = 0; s < 25; s++) begin
        checks++;
        if (late[s] !== want[s]) begin errors++; $display("FAIL rand%0d_slot%0d got=%b want=%b", n, s, late[s], want[s]); end
        if (s > 0 && want[s] !== want[s-1]) begin
          checks++;
          if (early[s] !== want[s-1]) begin errors++; $display("FAIL rand%0d_latency_slot%0d got=%b want=%b", n, s, early[s], want[s-1]); end
        end
      end
      checks++;
      if (fd1 - fd0 !== 1) begin errors++; $display("FAIL rand%0d_done_count got=%0d want=1", n, fd1 - fd0); end
    end
  endtask

  task automatic test_reload();
    logic [24:0] want1, want2;
    logic [11:0] a2, b2;
    logic        e, l, d;
    int          fd0;
    j1.joy_a = 12'($urandom);
    j1.joy_b = 12'($urandom);
    want1 = model_frame(j1.joy_a, j1.joy_b);
    fd0 = fd1;
    rise1(1'b0, e, l, d);
    for (int s = 1; s < 10; s++) begin
      rise1(1'b1, e, l, d);
      checks++;
      if (l !== want1[s]) begin errors++; $display("FAIL reload_pre_slot%0d got=%b want=%b", s, l, want1[s]); end
    end
    a2 = 12'($urandom);
    b2 = 12'($urandom);
    j1.joy_a = a2;
    j1.joy_b = b2;
    want2 = model_frame(a2, b2);
    rise1(1'b0, e, l, d);
    checks++;
    if (l !== 1'b1) begin errors++; $display("FAIL reload_slot0 got=%b want=1", l); end
    for (int s = 1; s < 25; s++) begin
      rise1(1'b1, e, l, d);
      checks++;
      if (l !== want2[s]) begin errors++; $display("FAIL reload_slot%0d got=%b want=%b", s, l, want2[s]); end
    end
    checks++;
    if (fd1 - fd0 !== 1) begin errors++; $display("FAIL reload_done_count got=%0d want=1", fd1 - fd0); end
  endtask

  task automatic test_watchdog();
    logic [24:0] want;
    logic [11:0] b;
    logic        l;
    b = 12'($urandom);
    j2.joy_a = 12'h000;
    j2.joy_b = b;
    want = model_frame(12'h000, b);
    rise2(1'b0, l);
    checks++;
    if (l !== 1'b1) begin errors++; $display("FAIL wd_slot0 got=%b want=1", l); end
    for (int s = 1; s < 4; s++) begin
      rise2(1'b1, l);
      checks++;
      if (l !== want[s]) begin errors++; $display("FAIL wd_slot%0d got=%b want=%b", s, l, want[s]); end
    end
    repeat (4) @(negedge pclk);
    checks++;
    if (j2.joy_data !== want[3]) begin errors++; $display("FAIL wd_early_expiry got=%b want=%b", j2.joy_data, want[3]); end
    repeat (30) @(negedge pclk);
    checks++;
    if (j2.joy_data !== 1'b1) begin errors++; $display("FAIL wd_timeout got=%b want=1", j2.joy_data); end
    for (int k = 0; k < 3; k++) begin
      rise2(1'b1, l);
      checks++;
      if (l !== 1'b1) begin errors++; $display("FAIL wd_after_edge%0d got=%b want=1", k, l); end
    end
    checks++;
    if (fd2 !== 0) begin errors++; $display("FAIL wd_done_count got=%0d want=0", fd2); end
  endtask

  task automatic test_reset_midframe();
    logic e, l, d;
    int   fd0;
    j1.joy_a = 12'h000;
    j1.joy_b = 12'($urandom);
    fd0 = fd1;
    rise1(1'b0, e, l, d);
    for (int s = 1; s < 5; s++) rise1(1'b1, e, l, d);
    checks++;
    if (l !== 1'b0) begin errors++; $display("FAIL rstmid_slot4 got=%b want=0", l); end
    @(negedge pclk);
    j1.joy_load = 1'b1;
    repeat (15) @(negedge pclk);
    j1.joy_clk = 1'b1;
    repeat (2) @(posedge pclk);
    #1 reset = 1'b1;
    @(posedge pclk);
    #1;
    checks++;
    if (j1.joy_data !== 1'b1) begin errors++; $display("FAIL rstmid_data got=%b want=1", j1.joy_data); end
    checks++;
    if (j1.frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b want=0", j1.frame_done); end
    repeat (2) @(posedge pclk);
    #1 reset = 1'b0;
    repeat (12) @(negedge pclk);
    j1.joy_clk = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rise1(1'b1, e, l, d);
      checks++;
      if (l !== 1'b1) begin errors++; $display("FAIL rstmid_after_edge%0d got=%b want=1", k, l); end
    end
    checks++;
    if (fd1 - fd0 !== 0) begin errors++; $display("FAIL rstmid_done_count got=%0d want=0", fd1 - fd0); end
  endtask

  initial begin
    j1.joy_clk  = 1'b0;
    j1.joy_load = 1'b1;
    j1.joy_a    = '1;
    j1.joy_b    = '1;
    j2.joy_clk  = 1'b0;
    j2.joy_load = 1'b1;
    j2.joy_a    = '1;
    j2.joy_b    = '1;
    test_reset();
    test_full_frame();
    test_midframe_change();
    test_random_frames();
    test_reload();
    test_watchdog();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
